// File: rtl/readout_integrator_if.sv
// readout_integrator_if: control, sample stream and result
// bundle between the measurement controller and the integrator.
interface readout_integrator_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 10
);
  logic                         start;
  logic [LEN_WIDTH-1:0]         int_len;
  logic signed [ACC_WIDTH-1:0]  threshold;
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] i_in;
  logic signed [DATA_WIDTH-1:0] q_in;
  logic                         busy;
  logic                         out_valid;
  logic signed [ACC_WIDTH-1:0]  i_sum;
  logic signed [ACC_WIDTH-1:0]  q_sum;
  logic                         state_bit;
  logic                         sat_flag;

  modport master (
    output start, int_len, threshold,
    output in_valid, i_in, q_in,
    input  busy, out_valid, i_sum, q_sum,
    input  state_bit, sat_flag
  );

  modport slave (
    input  start, int_len, threshold,
    input  in_valid, i_in, q_in,
    output busy, out_valid, i_sum, q_sum,
    output state_bit, sat_flag
  );
endinterface

// File: rtl/readout_integrator.sv
// readout_integrator: windowed saturating I/Q integration
// with threshold discrimination of the qubit state.
module readout_integrator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 10
) (
  input logic                 clk,
  input logic                 rst,
  readout_integrator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] thr_q, thr_d;
  logic signed [ACC_WIDTH-1:0] iacc_q, iacc_d;
  logic signed [ACC_WIDTH-1:0] qacc_q, qacc_d;
  logic                        sat_q, sat_d;
  logic signed [ACC_WIDTH-1:0] isum_q, isum_d;
  logic signed [ACC_WIDTH-1:0] qsum_q, qsum_d;
  logic                        stb_q, stb_d;
  logic                        satf_q, satf_d;

  logic accept;
  logic last;
  logic iov, qov;

  // Add one extra bit of headroom, then clamp when the
  // top two bits disagree (result left the signed range).
  function automatic logic signed [ACC_WIDTH-1:0] sadd(
    input  logic signed [ACC_WIDTH-1:0]  a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic                         ov
  );
    logic signed [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a}
      + {{(ACC_WIDTH+1-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
    ov = s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
    sadd = s[ACC_WIDTH-1:0];
    if (ov && s[ACC_WIDTH])
      sadd = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else if (ov)
      sadd = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  endfunction

  assign accept = (state_q == INTEG) && bus.in_valid;
  assign last   = accept && (cnt_q == len_q - 1'b1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start)
          state_d = (bus.int_len == '0) ? DONE : INTEG;
      end
      INTEG: begin
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // Window setup, accumulation and result capture
  always_comb begin
    len_d  = len_q;
    cnt_d  = cnt_q;
    thr_d  = thr_q;
    iacc_d = iacc_q;
    qacc_d = qacc_q;
    sat_d  = sat_q;
    isum_d = isum_q;
    qsum_d = qsum_q;
    stb_d  = stb_q;
    satf_d = satf_q;
    iov    = 1'b0;
    qov    = 1'b0;
    if (state_q == IDLE && bus.start) begin
      len_d  = bus.int_len;
      thr_d  = bus.threshold;
      cnt_d  = '0;
      iacc_d = '0;
      qacc_d = '0;
      sat_d  = 1'b0;
    end else if (accept) begin
      cnt_d  = cnt_q + 1'b1;
      iacc_d = sadd(iacc_q, bus.i_in, iov);
      qacc_d = sadd(qacc_q, bus.q_in, qov);
      sat_d  = sat_q | iov | qov;
    end
    // Capture on the edge entering DONE so results are
    // visible together with out_valid.
    if (state_d == DONE) begin
      isum_d = iacc_d;
      qsum_d = qacc_d;
      stb_d  = (iacc_d >= thr_d);
      satf_d = sat_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= '0;
      cnt_q  <= '0;
      thr_q  <= '0;
      iacc_q <= '0;
      qacc_q <= '0;
      sat_q  <= 1'b0;
      isum_q <= '0;
      qsum_q <= '0;
      stb_q  <= 1'b0;
      satf_q <= 1'b0;
    end else begin
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      thr_q  <= thr_d;
      iacc_q <= iacc_d;
      qacc_q <= qacc_d;
      sat_q  <= sat_d;
      isum_q <= isum_d;
      qsum_q <= qsum_d;
      stb_q  <= stb_d;
      satf_q <= satf_d;
    end
  end

  assign bus.i_sum     = isum_q;
  assign bus.q_sum     = qsum_q;
  assign bus.state_bit = stb_q;
  assign bus.sat_flag  = satf_q;

endmodule

// File: tb/tb_readout_integrator.sv
// tb_readout_integrator: table-driven windows with a
// scoreboard of expected results checked on out_valid.
module tb_readout_integrator;

  localparam int DW = 16;
  localparam int AW = 17;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  readout_integrator_if #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)
  ) bus ();

  readout_integrator #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int len;
    int thr;
    int iv[8];
    int qv[8];
    int vpat;
    int ei;
    int eq;
    int est;
    int esat;
  } vec_t;

  typedef struct {
    int ei;
    int eq;
    int est;
    int esat;
    int cyc;
    int id;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic check(string nm, longint act, longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(bit s, int len, int thr,
                       bit v, int i, int q);
    bus.start     = s;
    bus.int_len   = LW'(len);
    bus.threshold = AW'(thr);
    bus.in_valid  = v;
    bus.i_in      = DW'(i);
    bus.q_in      = DW'(q);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int id, int ei, int eq,
                      int est, int esat);
    exp_t e;
    e.ei = ei; e.eq = eq; e.est = est; e.esat = esat;
    e.cyc = cyc + 1;
    e.id = id;
    sb.push_back(e);
  endtask

  // Scoreboard: every strobe must match the oldest
  // expectation, including the cycle it was due on.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious_out_valid: got 1 expected 0 at cycle %0d",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("w%0d_cycle", e.id), cyc, e.cyc);
        check($sformatf("w%0d_i_sum", e.id), bus.i_sum, e.ei);
        check($sformatf("w%0d_q_sum", e.id), bus.q_sum, e.eq);
        check($sformatf("w%0d_state_bit", e.id), bus.state_bit, e.est);
        check($sformatf("w%0d_sat_flag", e.id), bus.sat_flag, e.esat);
        check($sformatf("w%0d_busy", e.id), bus.busy, 1);
      end
    end
  end

  task automatic run_vec(int id, vec_t v);
    int k;
    int p;
    if (v.len == 0) push(id, v.ei, v.eq, v.est, v.esat);
    drive(1, v.len, v.thr, 1, 1000, 1000);
    step();
    check($sformatf("w%0d_busy_after_start", id), bus.busy, 1);
    k = 0;
    p = 0;
    while (k < v.len && p < 32) begin
      if (v.vpat[p]) begin
        drive(0, 0, 0, 1, v.iv[k], v.qv[k]);
        k++;
        if (k == v.len) push(id, v.ei, v.eq, v.est, v.esat);
      end else begin
        drive(0, 0, 0, 0, 1111, 1111);
      end
      p++;
      step();
    end
    drive(1, 1, 12345, 1, 2222, 2222);
    step();
    check($sformatf("w%0d_idle_after_done", id), bus.busy, 0);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vecs[0] = '{4, 0, '{100, -20, 30, 10, 0, 0, 0, 0},
                '{5, 5, 5, 5, 0, 0, 0, 0}, 'hFFFF, 120, 20, 1, 0};
    vecs[1] = '{3, -100, '{-50, -50, -50, 0, 0, 0, 0, 0},
                '{0, 0, 0, 0, 0, 0, 0, 0}, 'h29, -150, 0, 0, 0};
    vecs[2] = '{3, 0, '{32767, 32767, 32767, 0, 0, 0, 0, 0},
                '{-32768, -32768, -32768, 0, 0, 0, 0, 0},
                'hFFFF, 65535, -65536, 1, 1};
    vecs[3] = '{1, 0, '{1, 0, 0, 0, 0, 0, 0, 0},
                '{0, 0, 0, 0, 0, 0, 0, 0}, 'hFFFF, 1, 0, 1, 0};
    vecs[4] = '{0, 0, '{0, 0, 0, 0, 0, 0, 0, 0},
                '{0, 0, 0, 0, 0, 0, 0, 0}, 'hFFFF, 0, 0, 1, 0};
    vecs[5] = '{0, 1, '{0, 0, 0, 0, 0, 0, 0, 0},
                '{0, 0, 0, 0, 0, 0, 0, 0}, 'hFFFF, 0, 0, 0, 0};
    vecs[6] = '{2, 20, '{7, 8, 0, 0, 0, 0, 0, 0},
                '{-3, -4, 0, 0, 0, 0, 0, 0}, 'h5, 15, -7, 0, 0};
    vecs[7] = '{5, -200, '{-100, -50, 0, 25, 25, 0, 0, 0},
                '{1, 2, 3, 4, 5, 0, 0, 0}, 'hFFFF, -100, 15, 1, 0};
    vecs[8] = '{2, 15, '{7, 8, 0, 0, 0, 0, 0, 0},
                '{0, 0, 0, 0, 0, 0, 0, 0}, 'hFFFF, 15, 0, 1, 0};
    vecs[9] = '{4, 0, '{32767, 32767, 32767, -32768, 0, 0, 0, 0},
                '{0, 0, 0, 0, 0, 0, 0, 0}, 'hFFFF, 32767, 0, 1, 1};

    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) step();
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_i_sum", bus.i_sum, 0);
    check("rst_q_sum", bus.q_sum, 0);
    check("rst_state_bit", bus.state_bit, 0);
    check("rst_sat_flag", bus.sat_flag, 0);
    rst = 1'b0;
    step();

    for (int n = 0; n < 10; n++) run_vec(n, vecs[n]);

    // Reset mid-window after 2 of 8 samples.
    drive(1, 8, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 5, 5);
    step();
    step();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_i_sum", bus.i_sum, 0);
    check("midrst_q_sum", bus.q_sum, 0);
    check("midrst_state_bit", bus.state_bit, 0);
    check("midrst_sat_flag", bus.sat_flag, 0);
    repeat (5) step();
    drive(1, 2, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 7, 0);
    step();
    drive(0, 0, 0, 1, 8, 0);
    push(20, 15, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();

    // Start pulsed mid-window must not disturb it.
    drive(1, 4, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 10, 1);
    step();
    step();
    drive(1, 1, 1000, 1, 10, 1);
    step();
    drive(0, 0, 0, 1, -5, 1);
    push(21, 25, 4, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("midstart_idle", bus.busy, 0);
    repeat (4) step();

    for (int t = 0; t < 20 && sb.size() != 0; t++) step();
    check("pending_results", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
